// File: rtl/raster_scheduler.sv
// rtl/raster_scheduler.sv - frame sequencer: back-buffer clear, triangle dispatch, buffer swap
//
// Optional feature macro: RAST_WATCHDOG_EN (per-triangle watchdog; wd_fault tied 0 when undefined)
//
// Ports:
//   clk_in       system clock
//   rst_in       synchronous active-low reset
//   new_frame    single-cycle display frame boundary pulse
//   tri_count    triangles in the current object, latched when a render starts
//   tri_addr     triangle store read address (store has 1-cycle read latency)
//   tri_valid    single-cycle triangle issue pulse to the rasterizer
//   rast_busy    rasterizer is working on a triangle
//   clear_we     back-buffer clear write enable
//   clear_addr   back-buffer clear address, linear x + y*WIDTH
//   clear_data   clear word (colour 0, farthest depth)
//   obj_done     single-cycle buffer swap pulse
//   busy         registered: render in progress (not IDLE/DONE)
//   frame_drops  saturating count of frame boundaries missed by an unfinished render
//   wd_fault     single-cycle pulse when a triangle is abandoned by the watchdog
module raster_scheduler #(
    parameter int          WIDTH      = 360,
    parameter int          HEIGHT     = 360,
    parameter int          NUM_TRI    = 64,
    parameter int          TRI_AW     = $clog2(NUM_TRI),
    parameter logic [16:0] CLEAR_WORD = 17'h001FF,
    parameter int          WD_LIMIT   = 4096
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              new_frame,
    input  logic [TRI_AW:0]   tri_count,
    output logic [TRI_AW-1:0] tri_addr,
    output logic              tri_valid,
    input  logic              rast_busy,
    output logic              clear_we,
    output logic [16:0]       clear_addr,
    output logic [16:0]       clear_data,
    output logic              obj_done,
    output logic              busy,
    output logic [7:0]        frame_drops,
    output logic              wd_fault
);

    localparam logic [16:0]     LAST_ADDR = 17'(WIDTH * HEIGHT - 1);
    localparam logic [TRI_AW:0] MAX_TRI   = (TRI_AW + 1)'(NUM_TRI);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_END,
        S_DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [TRI_AW:0] tri_idx;
    logic [TRI_AW:0] tri_total;
    logic [TRI_AW:0] tri_next;
    logic [TRI_AW:0] count_sat;
    logic            tri_finish;
    logic            rendering;
    logic            waiting;
    logic            frame_start;
    logic            wd_timeout;

    assign tri_next    = tri_idx + 1'b1;
    assign count_sat   = (tri_count > MAX_TRI) ? MAX_TRI : tri_count;
    assign waiting     = (state == S_WAIT_START) || (state == S_WAIT_END);
    assign rendering   = (state != S_IDLE) && (state != S_DONE);
    assign frame_start = new_frame && ((state == S_IDLE) || (state == S_DONE));

    assign tri_addr   = tri_idx[TRI_AW-1:0];
    assign tri_valid  = (state == S_ISSUE);
    assign clear_we   = (state == S_CLEAR);
    assign clear_data = CLEAR_WORD;
    // Only a render that reached DONE may swap; the very first frame out of IDLE never does.
    assign obj_done   = rst_in && (state == S_DONE) && new_frame;

`ifdef RAST_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt;

    // Counts cycles spent waiting on the current triangle; held at the limit so it cannot wrap.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wd_cnt <= '0;
        end else if (state == S_FETCH) begin
            wd_cnt <= '0;
        end else if (waiting && (wd_cnt != WD_W'(WD_LIMIT))) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_timeout = waiting && (wd_cnt == WD_W'(WD_LIMIT));
    assign wd_fault   = wd_timeout;
`else
    assign wd_timeout = 1'b0;
    assign wd_fault   = 1'b0;
`endif

    always_comb begin
        next_state = state;
        tri_finish = 1'b0;
        case (state)
            S_IDLE: begin
                if (new_frame) next_state = S_CLEAR;
            end
            S_CLEAR: begin
                if (clear_addr == LAST_ADDR) begin
                    next_state = (tri_total == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT_START;
            S_WAIT_START: begin
                if (wd_timeout) tri_finish = 1'b1;
                else if (rast_busy) next_state = S_WAIT_END;
            end
            S_WAIT_END: begin
                if (wd_timeout || !rast_busy) tri_finish = 1'b1;
            end
            S_DONE: begin
                if (new_frame) next_state = S_CLEAR;
            end
            default: next_state = S_IDLE;
        endcase
        // Completed and abandoned triangles leave the wait states the same way.
        if (tri_finish) begin
            next_state = (tri_next == tri_total) ? S_DONE : S_FETCH;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state       <= S_IDLE;
            tri_idx     <= '0;
            tri_total   <= '0;
            clear_addr  <= '0;
            frame_drops <= '0;
            busy        <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != S_IDLE) && (next_state != S_DONE);

            if (frame_start) begin
                tri_total  <= count_sat;
                clear_addr <= '0;
            end

            // The address stops on the last pixel and stays there until the next clear.
            if ((state == S_CLEAR) && (clear_addr != LAST_ADDR)) begin
                clear_addr <= clear_addr + 1'b1;
            end

            if ((state == S_CLEAR) && (clear_addr == LAST_ADDR)) begin
                tri_idx <= '0;
            end else if (tri_finish) begin
                tri_idx <= tri_next;
            end

            if (new_frame && rendering && (frame_drops != 8'hFF)) begin
                frame_drops <= frame_drops + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_raster_scheduler.sv
// tb/tb_raster_scheduler.sv - directed self-checking bench for raster_scheduler
module tb_raster_scheduler;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int NT = 64;
    localparam int AW = 6;

    logic          clk_in    = 1'b0;
    logic          rst_in    = 1'b0;
    logic          new_frame = 1'b0;
    logic [AW:0]   tri_count = '0;
    logic          rast_busy = 1'b0;
    logic [AW-1:0] tri_addr;
    logic          tri_valid;
    logic          clear_we;
    logic [16:0]   clear_addr;
    logic [16:0]   clear_data;
    logic          obj_done;
    logic          busy;
    logic [7:0]    frame_drops;
    logic          wd_fault;

    int   checks     = 0;
    int   errors     = 0;
    int   busy_len   = 20;
    logic rast_abort = 1'b0;

    logic [52:0] outv;
    assign outv = {tri_valid, obj_done, clear_we, busy, wd_fault, frame_drops,
                   tri_addr, clear_addr, clear_data};

    localparam logic [52:0] RESET_VEC = {5'b0, 8'd0, 6'd0, 17'd0, 17'h001FF};

    raster_scheduler #(
        .WIDTH(W), .HEIGHT(H), .NUM_TRI(NT), .TRI_AW(AW),
        .CLEAR_WORD(17'h001FF), .WD_LIMIT(16)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .new_frame(new_frame),
        .tri_count(tri_count), .tri_addr(tri_addr), .tri_valid(tri_valid),
        .rast_busy(rast_busy), .clear_we(clear_we), .clear_addr(clear_addr),
        .clear_data(clear_data), .obj_done(obj_done), .busy(busy),
        .frame_drops(frame_drops), .wd_fault(wd_fault)
    );

    always #5 clk_in = ~clk_in;

    // Rasterizer model: busy from one cycle after tri_valid for busy_len cycles.
    initial begin
        forever begin
            @(posedge clk_in);
            if (tri_valid && !rast_abort) begin
                #1 rast_busy = 1'b1;
                for (int k = 0; k < busy_len && !rast_abort; k++) @(posedge clk_in);
                #1 rast_busy = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic pulse_frame(output logic od);
        new_frame = 1'b1;
        @(negedge clk_in);
        od = obj_done;
        @(posedge clk_in);
        #1;
        new_frame = 1'b0;
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        step(3);
        @(negedge clk_in);
        checks++;
        if (outv !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", outv, RESET_VEC);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        step(3);
        @(negedge clk_in);
        checks++;
        if (outv !== RESET_VEC) begin
            errors++;
            $display("FAIL idle_outputs got %h exp %h", outv, RESET_VEC);
        end
        step(1);
    endtask

    task automatic test_clear;
        logic od;
        tri_count = '0;
        pulse_frame(od);
        checks++;
        if (od !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_swap got %b exp 0", od);
        end
        for (int i = 0; i < W * H; i++) begin
            @(negedge clk_in);
            checks++;
            if ({clear_we, clear_addr, clear_data, tri_valid, busy} !==
                {1'b1, 17'(i), 17'h001FF, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL clear_cycle_%0d got we=%b addr=%0d data=%h tv=%b busy=%b exp we=1 addr=%0d data=1ff tv=0 busy=1",
                         i, clear_we, clear_addr, clear_data, tri_valid, busy, i);
            end
            @(posedge clk_in);
            #1;
        end
        @(negedge clk_in);
        checks++;
        if ({clear_we, busy, clear_addr} !== {1'b0, 1'b0, 17'd11}) begin
            errors++;
            $display("FAIL clear_end got we=%b busy=%b addr=%0d exp we=0 busy=0 addr=11",
                     clear_we, busy, clear_addr);
        end
        step(2);
        pulse_frame(od);
        checks++;
        if (od !== 1'b1) begin
            errors++;
            $display("FAIL done_swap got %b exp 1", od);
        end
        @(negedge clk_in);
        checks++;
        if ({obj_done, clear_we, clear_addr} !== {1'b0, 1'b1, 17'd0}) begin
            errors++;
            $display("FAIL clear_restart got od=%b we=%b addr=%0d exp od=0 we=1 addr=0",
                     obj_done, clear_we, clear_addr);
        end
        step(12);
        @(negedge clk_in);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_restart_done got busy=%b exp 0", busy);
        end
        step(1);
    endtask

    task automatic test_dispatch;
        logic od;
        int   busy_cycles = 0;
        int   pulses      = 0;
        int   addr_err    = 0;
        int   unstable    = 0;
        int   wd_seen     = 0;
        tri_count = 7'd3;
        busy_len  = 20;
        pulse_frame(od);
        checks++;
        if (od !== 1'b1) begin
            errors++;
            $display("FAIL dispatch_swap got %b exp 1", od);
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk_in);
            if (!busy) break;
            busy_cycles++;
            if (wd_fault) wd_seen++;
            if (tri_valid) begin
                if (tri_addr !== AW'(pulses)) addr_err++;
                pulses++;
            end
            if (rast_busy && (tri_addr !== AW'(pulses - 1))) unstable++;
            @(posedge clk_in);
            #1;
        end
        // 12 clear cycles + 3 x (fetch + issue + wait_start + 20 wait_end)
        checks++;
        if (busy_cycles != 81) begin
            errors++;
            $display("FAIL dispatch_length got %0d exp 81", busy_cycles);
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL dispatch_pulses got %0d exp 3", pulses);
        end
        checks++;
        if (addr_err != 0 || unstable != 0) begin
            errors++;
            $display("FAIL dispatch_addr got addr_err=%0d unstable=%0d exp 0 0", addr_err, unstable);
        end
        checks++;
        if (wd_seen != 0) begin
            errors++;
            $display("FAIL no_watchdog got %0d exp 0", wd_seen);
        end
        step(1);
    endtask

    task automatic test_overrun;
        logic od;
        int   swaps = 0;
        logic [7:0] d249 = '0;
        tri_count = 7'd2;
        busy_len  = 10000;
        pulse_frame(od);
        checks++;
        if (od !== 1'b1) begin
            errors++;
            $display("FAIL overrun_start_swap got %b exp 1", od);
        end
        for (int k = 1; k <= 4; k++) begin
            step(4999);
            pulse_frame(od);
            checks++;
            if ({od, frame_drops} !== {1'b0, 8'(k)}) begin
                errors++;
                $display("FAIL overrun_drop_%0d got od=%b drops=%0d exp od=0 drops=%0d",
                         k, od, frame_drops, k);
            end
        end
        step(4999);
        pulse_frame(od);
        checks++;
        if ({od, frame_drops} !== {1'b1, 8'd4}) begin
            errors++;
            $display("FAIL overrun_swap got od=%b drops=%0d exp od=1 drops=4", od, frame_drops);
        end
        step(20);
        for (int i = 0; i < 300; i++) begin
            pulse_frame(od);
            if (od) swaps++;
            if (i == 249) d249 = frame_drops;
            step(1);
        end
        checks++;
        if (d249 !== 8'd254) begin
            errors++;
            $display("FAIL drops_before_sat got %0d exp 254", d249);
        end
        checks++;
        if (frame_drops !== 8'd255) begin
            errors++;
            $display("FAIL drops_saturate got %0d exp 255", frame_drops);
        end
        checks++;
        if (swaps != 0) begin
            errors++;
            $display("FAIL overrun_no_swap got %0d exp 0", swaps);
        end
    endtask

    task automatic test_watchdog;
        logic od;
        int   tv0      = -1;
        int   tv1      = -1;
        int   wf       = -1;
        int   wf_count = 0;
        int   done_cyc = -1;
        logic [AW-1:0] addr1 = '0;
        tri_count = 7'd2;
        busy_len  = 30;
        pulse_frame(od);
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk_in);
            if (!busy) begin
                done_cyc = cyc;
                break;
            end
            if (tri_valid) begin
                if (tv0 < 0) tv0 = cyc;
                else begin
                    tv1   = cyc;
                    addr1 = tri_addr;
                end
            end
            if (wd_fault) begin
                if (wf < 0) wf = cyc;
                wf_count++;
            end
            @(posedge clk_in);
            #1;
        end
        checks++;
        if (wf - tv0 != 17 || wf_count != 1) begin
            errors++;
            $display("FAIL wd_fault_timing got delta=%0d count=%0d exp delta=17 count=1", wf - tv0, wf_count);
        end
        checks++;
        if (tv1 - wf != 2 || addr1 !== 6'd1) begin
            errors++;
            $display("FAIL wd_next_fetch got delta=%0d addr=%0d exp delta=2 addr=1", tv1 - wf, addr1);
        end
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL wd_done got timeout exp done");
        end
        step(1);
    endtask

    task automatic test_reset_mid;
        logic od;
        busy_len = 10000;
        pulse_frame(od);
        step(16);
        @(negedge clk_in);
        checks++;
        if ({busy, rast_busy, clear_we, tri_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL pre_reset_wait got busy=%b rast=%b we=%b tv=%b exp 1 1 0 0",
                     busy, rast_busy, clear_we, tri_valid);
        end
        @(posedge clk_in);
        #1;
        rst_in     = 1'b0;
        rast_abort = 1'b1;
        @(negedge clk_in);
        @(posedge clk_in);
        #1;
        checks++;
        if (outv !== RESET_VEC) begin
            errors++;
            $display("FAIL mid_reset got %h exp %h", outv, RESET_VEC);
        end
        step(1);
        rst_in = 1'b1;
        step(3);
        rast_abort = 1'b0;
        @(negedge clk_in);
        checks++;
        if (outv !== RESET_VEC) begin
            errors++;
            $display("FAIL post_reset_idle got %h exp %h", outv, RESET_VEC);
        end
        step(1);
    endtask

    initial begin
        test_reset;
        test_clear;
`ifdef RAST_WATCHDOG_EN
        test_watchdog;
`else
        test_dispatch;
        test_overrun;
`endif
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
